// File: rtl/ex_muldiv_iter_pkg.sv
// Shared definitions for the iterative EX-stage multiply/divide unit.
//   muldiv_op_e    : op_i encoding (MULT..MSUBU)
//   muldiv_state_e : controller states
//   op_is_div / op_is_signed : op_i decode helpers
package ex_muldiv_iter_pkg;

  typedef enum logic [2:0] {
    MULDIV_MULT  = 3'd0,
    MULDIV_MULTU = 3'd1,
    MULDIV_DIV   = 3'd2,
    MULDIV_DIVU  = 3'd3,
    MULDIV_MADD  = 3'd4,
    MULDIV_MADDU = 3'd5,
    MULDIV_MSUB  = 3'd6,
    MULDIV_MSUBU = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  // Even codes are the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_iter_step.sv
// Combinational BPC-bit iteration of the multiply/divide datapath.
//   i_div  : 1 = restoring shift-subtract, 0 = shift-add
//   i_opnd : multiplicand (MUL) or divisor (DIV), magnitude
//   i_part : partial register; MUL {acc_hi, multiplier_lo}, DIV {remainder, dividend/quotient}
//   o_part : partial register after BPC bits retired
module ex_muldiv_iter_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic [2*WIDTH-1:0] i_part,
  output logic [2*WIDTH-1:0] o_part
);

  logic [2*WIDTH-1:0] w_p;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_sh;
  logic [WIDTH:0]     w_dif;

  always_comb begin
    w_p   = i_part;
    w_sum = '0;
    w_sh  = '0;
    w_dif = '0;
    for (int unsigned i = 0; i < BPC; i++) begin
      if (i_div) begin
        // Shift {rem,quo} left; trial-subtract divisor from the widened remainder.
        w_sh  = {w_p, 1'b0};
        w_dif = w_sh[2*WIDTH:WIDTH] - {1'b0, i_opnd};
        if (!w_dif[WIDTH])
          w_p = {w_dif[WIDTH-1:0], w_sh[WIDTH-1:1], 1'b1};
        else
          w_p = w_sh[2*WIDTH-1:0];
      end else begin
        // Add multiplicand into the high half when the multiplier LSB is set, then shift right with carry.
        w_sum = {1'b0, w_p[2*WIDTH-1:WIDTH]} + (w_p[0] ? {1'b0, i_opnd} : '0);
        w_p   = {w_sum, w_p[WIDTH-1:1]};
      end
    end
    o_part = w_p;
  end

endmodule

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide unit for the EX stage.
//   clk, rst              : clock, asynchronous active-high reset
//   flush_i               : cancels any op in flight
//   start_i, op_i         : op request (accepted in IDLE/DONE), op code
//   opdata1_i, opdata2_i  : multiplicand/dividend, multiplier/divisor
//   hi_i, lo_i            : accumulate base for MADD*/MSUB*
//   busy_o                : high while iterating
//   ready_o, divzero_o    : one-cycle result strobe, divide-by-zero qualifier
//   result_o              : {hi,lo}; DIV* gives {remainder, quotient}
module ex_muldiv_iter
  import ex_muldiv_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [WIDTH-1:0]   hi_i,
  input  logic [WIDTH-1:0]   lo_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               divzero_o
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  muldiv_state_e      r_state;
  muldiv_op_e         r_op;
  logic [CW-1:0]      r_cnt;
  logic               r_sign1, r_sign2;
  logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_part, r_result;
  logic               r_busy, r_ready, r_divzero;

  logic               w_neg1, w_neg2, w_dz, w_is_div;
  logic [WIDTH-1:0]   w_abs1, w_abs2, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_step, w_prod, w_final;

  assign w_neg1   = op_is_signed(op_i) & opdata1_i[WIDTH-1];
  assign w_neg2   = op_is_signed(op_i) & opdata2_i[WIDTH-1];
  assign w_abs1   = w_neg1 ? -opdata1_i : opdata1_i;
  assign w_abs2   = w_neg2 ? -opdata2_i : opdata2_i;
  assign w_dz     = op_is_div(op_i) & (opdata2_i == '0);
  assign w_is_div = op_is_div(r_op);

  ex_muldiv_iter_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .i_div  (w_is_div),
    .i_opnd (r_opnd),
    .i_part (r_part),
    .o_part (w_step)
  );

  // Sign fixup and accumulate, applied to the value produced by the last step.
  always_comb begin
    w_prod = (r_sign1 ^ r_sign2) ? -w_step : w_step;
    w_quo  = (r_sign1 ^ r_sign2) ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
    w_rem  = r_sign1 ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
    case (r_op)
      MULDIV_MADD, MULDIV_MADDU: w_final = {r_hi, r_lo} + w_prod;
      MULDIV_MSUB, MULDIV_MSUBU: w_final = {r_hi, r_lo} - w_prod;
      MULDIV_DIV,  MULDIV_DIVU:  w_final = {w_rem, w_quo};
      default:                   w_final = w_prod;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= MULDIV_MULT;
      r_cnt     <= '0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_part    <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_divzero <= 1'b0;
    end else if (flush_i) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      case (r_state)
        ST_CALC: begin
          r_part <= w_step;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_result <= w_final;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_ready   <= 1'b0;
          r_divzero <= 1'b0;
          if (start_i) begin
            if (w_dz) begin
              r_state   <= ST_DONE;
              r_ready   <= 1'b1;
              r_divzero <= 1'b1;
              r_result  <= {opdata1_i, {WIDTH{1'b1}}};
            end else begin
              r_state <= ST_CALC;
              r_busy  <= 1'b1;
              r_op    <= muldiv_op_e'(op_i);
              r_sign1 <= w_neg1;
              r_sign2 <= w_neg2;
              r_hi    <= hi_i;
              r_lo    <= lo_i;
              r_cnt   <= CW'(STEPS - 1);
              if (op_is_div(op_i)) begin
                r_opnd <= w_abs2;
                r_part <= {{WIDTH{1'b0}}, w_abs1};
              end else begin
                r_opnd <= w_abs1;
                r_part <= {{WIDTH{1'b0}}, w_abs2};
              end
            end
          end
        end
      endcase
    end
  end

  assign busy_o    = r_busy;
  assign ready_o   = r_ready;
  assign divzero_o = r_divzero;
  assign result_o  = r_result;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Directed bench for ex_muldiv_iter: three instances (BPC 1, 2, 4) share one stimulus stream.
module tb_ex_muldiv_iter;

  logic        clk, rst, flush_i, start_i;
  logic [2:0]  op_i;
  logic [31:0] opdata1_i, opdata2_i, hi_i, lo_i;
  logic        w_busy [3];
  logic        w_ready [3];
  logic        w_dz [3];
  logic [63:0] w_result [3];

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv_iter #(.WIDTH(32), .BPC(1)) u_dut0 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
    .busy_o(w_busy[0]), .ready_o(w_ready[0]), .result_o(w_result[0]), .divzero_o(w_dz[0]));
  ex_muldiv_iter #(.WIDTH(32), .BPC(2)) u_dut1 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
    .busy_o(w_busy[1]), .ready_o(w_ready[1]), .result_o(w_result[1]), .divzero_o(w_dz[1]));
  ex_muldiv_iter #(.WIDTH(32), .BPC(4)) u_dut2 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
    .busy_o(w_busy[2]), .ready_o(w_ready[2]), .result_o(w_result[2]), .divzero_o(w_dz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo);
    start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hi; lo_i = lo;
  endtask

  // Takes the accepting edge, scrambles inputs, then watches each instance for 36 cycles.
  task automatic collect(input string tag, input logic [63:0] exp, input logic exp_dz);
    int          lat [3];
    int          nb [3];
    int          nr [3];
    logic [63:0] res [3];
    logic        dzv [3];
    int          steps;
    for (int k = 0; k < 3; k++) begin
      lat[k] = -1; nb[k] = 0; nr[k] = 0; res[k] = '0; dzv[k] = 1'b0;
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    op_i = 3'($urandom); opdata1_i = $urandom; opdata2_i = $urandom; hi_i = $urandom; lo_i = $urandom;
    for (int c = 0; c < 36; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (w_busy[k]) nb[k]++;
        if (w_ready[k]) begin
          nr[k]++;
          if (lat[k] < 0) begin lat[k] = c; res[k] = w_result[k]; dzv[k] = w_dz[k]; end
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      steps = exp_dz ? 0 : (32 >> k);
      check($sformatf("%s_res_b%0d", tag, 1 << k), res[k], exp);
      check($sformatf("%s_dz_b%0d", tag, 1 << k), 64'(dzv[k]), 64'(exp_dz));
      check($sformatf("%s_lat_b%0d", tag, 1 << k), 64'(lat[k]), 64'(steps));
      check($sformatf("%s_busy_b%0d", tag, 1 << k), 64'(nb[k]), 64'(steps));
      check($sformatf("%s_pulses_b%0d", tag, 1 << k), 64'(nr[k]), 64'd1);
      check($sformatf("%s_hold_b%0d", tag, 1 << k), w_result[k], exp);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo, input logic [63:0] exp, input logic exp_dz);
    @(negedge clk);
    issue(op, a, b, hi, lo);
    collect(tag, exp, exp_dz);
  endtask

  initial begin
    int nr;
    rst = 1'b1; flush_i = 1'b0; start_i = 1'b0; op_i = '0;
    opdata1_i = '0; opdata2_i = '0; hi_i = '0; lo_i = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("reset_b%0d", 1 << k), {w_result[k], w_busy[k], w_ready[k], w_dz[k]}, '0);
    @(negedge clk);
    rst = 1'b0;

    run("mult",    3'd0, 32'hFFFFFFFD, 32'h00000005, '0, '0, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
    run("div",     3'd2, 32'hFFFFFFF9, 32'h00000002, '0, '0, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run("divu",    3'd3, 32'hFFFFFFF9, 32'h00000002, '0, '0, 64'h00000001_7FFFFFFC, 1'b0);
    run("divu_z",  3'd3, 32'h12345678, 32'h00000000, '0, '0, 64'h12345678_FFFFFFFF, 1'b1);
    run("div_z",   3'd2, 32'h80000001, 32'h00000000, '0, '0, 64'h80000001_FFFFFFFF, 1'b1);
    run("maddu",   3'd5, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0);
    run("msub",    3'd6, 32'h00000002, 32'h00000003, '0, '0, 64'hFFFFFFFF_FFFFFFFA, 1'b0);
    run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, '0, '0, 64'h00000000_80000000, 1'b0);
    run("multu_m", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 64'hFFFFFFFE_00000001, 1'b0);
    run("div_mix", 3'd2, 32'h00000007, 32'hFFFFFFFE, '0, '0, 64'h00000001_FFFFFFFD, 1'b0);
    run("madd",    3'd4, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h00000010, 64'h00000000_0000000A, 1'b0);
    run("msubu",   3'd7, 32'h00000002, 32'h80000000, 32'h1, 32'h0, 64'h0, 1'b0);
    run("mult_mn", 3'd0, 32'h80000000, 32'h80000000, '0, '0, 64'h40000000_00000000, 1'b0);

    // Flush during CALC: no strobe, busy drops, previous result held.
    @(negedge clk);
    issue(3'd0, 32'h3, 32'h5, '0, '0);
    @(posedge clk); #1;
    start_i = 1'b0;
    nr = 0;
    for (int c = 0; c < 45; c++) begin
      for (int k = 0; k < 3; k++) if (w_ready[k]) nr++;
      if (c == 5) flush_i = 1'b1;
      if (c == 6) begin
        flush_i = 1'b0;
        for (int k = 0; k < 3; k++) check($sformatf("flush_busy_b%0d", 1 << k), 64'(w_busy[k]), 64'd0);
      end
      @(posedge clk); #1;
    end
    check("flush_noready", 64'(nr), 64'd0);
    for (int k = 0; k < 3; k++)
      check($sformatf("flush_hold_b%0d", 1 << k), w_result[k], 64'h40000000_00000000);
    run("post_flush", 3'd1, 32'd7, 32'd6, '0, '0, 64'd42, 1'b0);

    // Flush and start in the same cycle: start is dropped.
    @(negedge clk);
    issue(3'd1, 32'd2, 32'd2, '0, '0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    nr = 0;
    for (int k = 0; k < 3; k++) check($sformatf("fs_busy_b%0d", 1 << k), 64'(w_busy[k]), 64'd0);
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < 3; k++) if (w_ready[k]) nr++;
      @(posedge clk); #1;
    end
    check("fs_noready", 64'(nr), 64'd0);
    check("fs_hold", w_result[0], 64'd42);

    // Back-to-back: the next op is offered while the BPC=1 instance sits in DONE.
    @(negedge clk);
    issue(3'd1, 32'd3, 32'd4, '0, '0);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 0; c < 40 && !w_ready[0]; c++) begin
      @(posedge clk); #1;
    end
    check("b2b_first_rdy", 64'(w_ready[0]), 64'd1);
    check("b2b_first_res", w_result[0], 64'd12);
    issue(3'd1, 32'd5, 32'd5, '0, '0);
    collect("b2b", 64'd25, 1'b0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    issue(3'd0, 32'h11, 32'h3, '0, '0);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("rst_mid_b%0d", 1 << k), {w_result[k], w_busy[k], w_ready[k], w_dz[k]}, '0);
    @(negedge clk);
    rst = 1'b0;
    nr = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) if (w_ready[k]) nr++;
    end
    check("rst_noready", 64'(nr), 64'd0);
    run("post_rst", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 64'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
